bin2bcd_seq: RTL and testbench

//   Iterative (shift-add-3 / double-dabble) binary-to-BCD converter, one bit per clock.

---
 rtl/bin2bcd_seq.sv | 141 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Iterative shift-add-3 (double-dabble) binary-to-BCD converter, one input
//   bit per clock. The result is registered and held between conversions so
//   a downstream display scanner can sample it at any time.
//
//   Parameters
//     WIDTH   binary input width (>= 1)
//     DIGITS  BCD digits produced; digit 0 = bcd[3:0] (ones)
//
//   Ports
//     clk    in   system clock, all logic on posedge
//     rst    in   synchronous active-high reset
//     start  in   conversion request, sampled only while idle
//     bin    in   binary value, captured on the accepting edge
//     busy   out  high while a conversion is in progress
//     done   out  one-cycle pulse, bcd/ovf updated this cycle
//     bcd    out  packed BCD result, held until next done
//     ovf    out  value >= 10**DIGITS; bcd holds the low DIGITS digits
//     blank  out  (BIN2BCD_BLANK_EN only) leading-zero flags per digit,
//                 blank[0] always 0
//
//   Build option: define BIN2BCD_BLANK_EN to add the blank output.

module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t              r_state;
  logic [WIDTH-1:0]    r_bin;
  logic [4*DIGITS-1:0] r_dig;
  logic                r_sovf;
  logic [CW-1:0]       r_cnt;

  logic [4*DIGITS-1:0] w_adj;
  logic [4*DIGITS-1:0] w_dig_nxt;
  logic [WIDTH-1:0]    w_bin_nxt;
  logic                w_carry;
  logic                w_last;

  // Add-3 is applied per 4-bit digit before the shift; no inter-digit carry.
  always_comb begin
    w_adj = r_dig;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_dig[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_dig[4*i +: 4] + 4'd3;
    end
  end

  // Bit leaving the top digit means the value needs more than DIGITS digits.
  assign w_carry   = w_adj[4*DIGITS-1];
  assign w_dig_nxt = {w_adj[4*DIGITS-2:0], r_bin[WIDTH-1]};
  assign w_bin_nxt = r_bin << 1;
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] w_blank_nxt;
  logic              w_zero_run;

  // Walk from the top digit down; a digit blanks while everything at or
  // above it is zero. The ones digit is never blanked.
  always_comb begin
    w_blank_nxt = '0;
    w_zero_run  = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      w_zero_run = w_zero_run & (w_dig_nxt[4*(DIGITS-1-k) +: 4] == 4'd0);
      if (k != DIGITS - 1)
        w_blank_nxt[DIGITS-1-k] = w_zero_run;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_bin   <= '0;
      r_dig   <= '0;
      r_sovf  <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
      blank   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bin   <= bin;
            r_dig   <= '0;
            r_sovf  <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_dig  <= w_dig_nxt;
          r_bin  <= w_bin_nxt;
          r_sovf <= r_sovf | w_carry;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            bcd     <= w_dig_nxt;
            ovf     <= r_sovf | w_carry;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
`ifdef BIN2BCD_BLANK_EN
            blank   <= w_blank_nxt;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bin   = '0;

  logic        busy_a, done_a, ovf_a;
  logic [31:0] bcd_a;
  logic        busy_b, done_b, ovf_b;
  logic [7:0]  bcd_b;
`ifdef BIN2BCD_BLANK_EN
  logic [7:0]  blank_a;
  logic [1:0]  blank_b;
`endif

  bin2bcd_seq #(.WIDTH(16), .DIGITS(8)) u_dut_a (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy_a),
    .done  (done_a),
    .bcd   (bcd_a),
    .ovf   (ovf_a)
`ifdef BIN2BCD_BLANK_EN
    ,
    .blank (blank_a)
`endif
  );

  bin2bcd_seq #(.WIDTH(16), .DIGITS(2)) u_dut_b (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy_b),
    .done  (done_b),
    .bcd   (bcd_b),
    .ovf   (ovf_b)
`ifdef BIN2BCD_BLANK_EN
    ,
    .blank (blank_b)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits by plain division, low digit first.
  function automatic logic [31:0] to_bcd(input int unsigned v, input int unsigned nd);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int unsigned i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic too_big(input int unsigned v, input int unsigned nd);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < nd; i++) p = p * 10;
    return longint'(v) >= p;
  endfunction

  function automatic logic [31:0] blank_of(input logic [31:0] b, input int unsigned nd);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 1; i < nd; i++)
      r[i] = ((b >> (4*i)) == 32'd0);
    return r;
  endfunction

  // Transaction-level model: a conversion occupies WIDTH cycles after its
  // accepting edge, results appear with done, and reset drops everything.
  int          m_left = 0;
  int unsigned m_val  = 0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_bcd_a = '0, m_bcd_b = '0;
  logic        m_ovf_a = 1'b0, m_ovf_b = 1'b0;
  logic        chk_en = 1'b0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_left  = 0;
      m_busy  = 1'b0;
      m_bcd_a = '0;
      m_bcd_b = '0;
      m_ovf_a = 1'b0;
      m_ovf_b = 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        m_val  = int'(bin);
        m_left = 16;
        m_busy = 1'b1;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_busy  = 1'b0;
        m_done  = 1'b1;
        m_bcd_a = to_bcd(m_val, 8);
        m_bcd_b = to_bcd(m_val, 2);
        m_ovf_a = too_big(m_val, 8);
        m_ovf_b = too_big(m_val, 2);
      end
    end
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy_a", 32'(busy_a), 32'(m_busy));
      chk("done_a", 32'(done_a), 32'(m_done));
      chk("bcd_a",  bcd_a,       m_bcd_a);
      chk("ovf_a",  32'(ovf_a),  32'(m_ovf_a));
      chk("busy_b", 32'(busy_b), 32'(m_busy));
      chk("done_b", 32'(done_b), 32'(m_done));
      chk("bcd_b",  32'(bcd_b),  m_bcd_b);
      chk("ovf_b",  32'(ovf_b),  32'(m_ovf_b));
`ifdef BIN2BCD_BLANK_EN
      chk("blank_a", 32'(blank_a), blank_of(m_bcd_a, 8));
      chk("blank_b", 32'(blank_b), blank_of(m_bcd_b, 2));
`endif
    end
  end

  // Advance negedges until done_a is seen, counting cycles and busy cycles.
  task automatic wait_done(inout int n, inout int busy_cnt);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      n++;
      guard++;
      if (busy_a) busy_cnt++;
    end while (!done_a && guard < 200);
    if (!done_a) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: got no done expected done within 200 cycles");
    end
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done_a) cnt++;
    end
  endtask

  initial begin
    int n, bc, nd;

    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_bcd",  bcd_a,       32'd0);
    chk("rst_ovf",  32'(ovf_a),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 9876: latency and busy duration; bin changes mid-conversion
    bin = 16'd9876; start = 1'b1;
    @(negedge clk); n = 1; bc = 32'(busy_a);
    start = 1'b0; bin = 16'hBEEF;
    wait_done(n, bc);
    chk("lat_9876",  32'(n),     32'd17);
    chk("busy_9876", 32'(bc),    32'd16);
    chk("bcd_9876",  bcd_a,      32'h00009876);
    chk("ovf_9876",  32'(ovf_a), 32'd0);
    chk("bcdb_9876", 32'(bcd_b), 32'h76);
    chk("ovfb_9876", 32'(ovf_b), 32'd1);
`ifdef BIN2BCD_BLANK_EN
    chk("blank_9876", 32'(blank_a), 32'b11110000);
`endif
    repeat (3) @(negedge clk);

    // 65535 then 0 with start held high
    bin = 16'd65535; start = 1'b1;
    @(negedge clk); n = 1; bc = 0;
    bin = 16'd0;
    wait_done(n, bc);
    chk("lat_65535", 32'(n),  32'd17);
    chk("bcd_65535", bcd_a,   32'h00065535);
    wait_done(n, bc);
    start = 1'b0;
    chk("lat_0",     32'(n),  32'd34);
    chk("bcd_0",     bcd_a,   32'h0);
`ifdef BIN2BCD_BLANK_EN
    chk("blank_0", 32'(blank_a), 32'b11111110);
`endif
    repeat (3) @(negedge clk);

    // 1234, second start while busy is ignored
    bin = 16'd1234; start = 1'b1;
    @(negedge clk); n = 1; bc = 0;
    start = 1'b0;
    @(negedge clk); n++;
    @(negedge clk); n++;
    bin = 16'd42; start = 1'b1;
    @(negedge clk); n++;
    start = 1'b0;
    wait_done(n, bc);
    chk("lat_1234", 32'(n), 32'd17);
    chk("bcd_1234", bcd_a,  32'h00001234);
    count_dones(25, nd);
    chk("no_extra_done", 32'(nd), 32'd0);

    // 500 aborted by reset mid-conversion
    bin = 16'd500; start = 1'b1;
    @(negedge clk); n = 1;
    start = 1'b0;
    while (n < 7) begin
      @(negedge clk); n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_dones(25, nd);
    chk("abort_no_done", 32'(nd),     32'd0);
    chk("abort_bcd",     bcd_a,       32'd0);
    chk("abort_busy",    32'(busy_a), 32'd0);
    bin = 16'd500; start = 1'b1;
    @(negedge clk); n = 1; bc = 0;
    start = 1'b0;
    wait_done(n, bc);
    chk("lat_500", 32'(n), 32'd17);
    chk("bcd_500", bcd_a,  32'h00000500);
    repeat (3) @(negedge clk);

    // 123 on the two-digit converter overflows
    bin = 16'd123; start = 1'b1;
    @(negedge clk); n = 1; bc = 0;
    start = 1'b0;
    wait_done(n, bc);
    chk("bcd_123",  bcd_a,       32'h00000123);
    chk("bcdb_123", 32'(bcd_b),  32'h23);
    chk("ovfb_123", 32'(ovf_b),  32'd1);
    chk("ovf_123",  32'(ovf_a),  32'd0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
